layer1_streamer: RTL and testbench

//  Downstream stage of the atrous-conv/max-pool engine. After the engine finishes, it reads
//  the 32x32 Layer1 feature map (13-bit, 9.4 fixed point) from the shared result memory.
//  It streams the words in raster order over a valid/ready interface and tracks the running

---
 rtl/layer1_streamer_if.sv | 26 ++
 rtl/layer1_streamer.sv | 161 ++++++++++++++++
 tb/tb_layer1_streamer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer1_streamer_if.sv
// Layer1 streamer bus bundle: result-memory read port plus the valid/ready output stream.
// master = streamer side, slave = memory/consumer side.
interface layer1_streamer_if #(
  parameter int AW = 12,
  parameter int DW = 13
);
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          csel;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [9:0]    out_idx;
  logic          out_last;

  modport master (
    output crd, caddr_rd, csel, out_valid, out_data, out_idx, out_last,
    input  cdata_rd, out_ready
  );

  modport slave (
    input  crd, caddr_rd, csel, out_valid, out_data, out_idx, out_last,
    output cdata_rd, out_ready
  );
endinterface

// File: rtl/layer1_streamer.sv
// Reads the Layer1 feature map from result memory, streams it in raster order through a
// small credit-controlled FIFO and tracks the running maximum and its first index.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// READ  | issuing reads while FIFO + inflight has room
// DRAIN | all reads issued, waiting for the last word to be accepted
// DONE  | one-cycle done pulse, busy low
module layer1_streamer #(
  parameter int NUM_WORDS  = 1024,
  parameter int AW         = 12,
  parameter int DW         = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     max_val,
  output logic [9:0]        max_idx,
  layer1_streamer_if.master bus
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] LAST_RD   = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] WORDS_CW  = CW'(NUM_WORDS);
  localparam logic [9:0]    LAST_IDX  = 10'(NUM_WORDS - 1);
  localparam logic [PW:0]   DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] acc_cnt;
  logic          rd_pend;
  logic [9:0]    pend_idx;

  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [9:0]    fifo_idx  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   fifo_cnt;

  logic          start_ok;
  logic          credit_ok;
  logic          rd_issue;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic          handshake;
  logic [PW+1:0] occupancy;

  assign start_ok   = (state == S_IDLE) && start;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_CNT);

  // Credit counts the word still in flight from last cycle's read so the FIFO never overflows.
  assign occupancy  = {1'b0, fifo_cnt} + (PW + 2)'(rd_pend);
  assign credit_ok  = occupancy < (PW + 2)'(FIFO_DEPTH);
  assign rd_issue   = (state == S_READ) && credit_ok && (rd_cnt < WORDS_CW);

  assign fifo_push  = rd_pend;
  assign handshake  = bus.out_valid && bus.out_ready;
  assign fifo_pop   = handshake;

  assign busy          = (state == S_READ) || (state == S_DRAIN);
  assign done          = (state == S_DONE);
  assign bus.csel      = busy;
  assign bus.crd       = rd_issue;
  assign bus.caddr_rd  = AW'(rd_cnt);
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_data[rd_ptr];
  assign bus.out_idx   = fifo_empty ? '0 : fifo_idx[rd_ptr];
  assign bus.out_last  = bus.out_valid && (bus.out_idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  if (rd_issue && (rd_cnt == LAST_RD)) state_nxt = S_DRAIN;
      S_DRAIN: if (handshake && bus.out_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      rd_cnt   <= '0;
      acc_cnt  <= '0;
      rd_pend  <= 1'b0;
      pend_idx <= '0;
      max_val  <= '0;
      max_idx  <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_issue;
      if (rd_issue) begin
        pend_idx <= 10'(rd_cnt);
      end
      if (start_ok) begin
        rd_cnt  <= '0;
        acc_cnt <= '0;
        max_val <= '0;
        max_idx <= '0;
      end else begin
        if (rd_issue) begin
          rd_cnt <= rd_cnt + CW'(1);
        end
        if (handshake) begin
          acc_cnt <= acc_cnt + CW'(1);
          // Strict compare keeps the earliest index on ties.
          if ((acc_cnt == '0) || (bus.out_data > max_val)) begin
            max_val <= bus.out_data;
            max_idx <= bus.out_idx;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted in fifo_cnt.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= bus.cdata_rd;
      fifo_idx[wr_ptr]  <= pend_idx;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_layer1_streamer.sv
// Self-checking bench for layer1_streamer: a memory responder, a random-duty consumer and a
// reference model built from the expected raster sequence and a first-max scan of memory.
module tb_layer1_streamer;

  localparam int NUM_WORDS  = 1024;
  localparam int AW         = 12;
  localparam int DW         = 13;
  localparam int FIFO_DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [DW-1:0] max_val;
  logic [9:0]    max_idx;

  layer1_streamer_if #(.AW(AW), .DW(DW)) bus ();

  layer1_streamer #(
    .NUM_WORDS (NUM_WORDS),
    .AW        (AW),
    .DW        (DW),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .max_val(max_val),
    .max_idx(max_idx),
    .bus    (bus)
  );

  logic [DW-1:0] mem [NUM_WORDS];
  int n_cmp = 0;
  int n_err = 0;
  int n_issued = 0;
  int n_accepted = 0;
  int n_done = 0;
  int ready_duty = 0;
  int exp_max = 0;
  int exp_max_idx = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic [9:0]    stall_idx;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Result memory: data appears the cycle after the strobe is sampled.
  always @(posedge clk) begin
    if (bus.crd) bus.cdata_rd <= mem[bus.caddr_rd];
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 99) < ready_duty);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.crd) begin
        chk("rd_credit", (n_issued - n_accepted) < FIFO_DEPTH, 1);
        chk("rd_range", n_issued < NUM_WORDS, 1);
        chk("rd_addr", bus.caddr_rd, n_issued);
        n_issued++;
      end
      if (stall_prev) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, stall_data);
        chk("stall_idx", bus.out_idx, stall_idx);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_count", n_accepted < NUM_WORDS, 1);
        if (n_accepted < NUM_WORDS) begin
          chk("out_idx", bus.out_idx, n_accepted);
          chk("out_data", bus.out_data, mem[n_accepted]);
          chk("out_last", bus.out_last, n_accepted == NUM_WORDS - 1);
        end
        n_accepted++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      stall_idx  = bus.out_idx;
      if (busy) chk("csel", bus.csel, 1);
      if (done) begin
        n_done++;
        chk("done_busy", busy, 0);
      end
    end
  end

  task automatic fill_ramp();
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = DW'(i * 16);
  endtask

  task automatic fill_random(input int hi);
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = DW'($urandom_range(0, hi));
  endtask

  task automatic begin_pass();
    n_issued    = 0;
    n_accepted  = 0;
    n_done      = 0;
    exp_max     = mem[0];
    exp_max_idx = 0;
    for (int i = 1; i < NUM_WORDS; i++) begin
      if (mem[i] > exp_max) begin
        exp_max     = mem[i];
        exp_max_idx = i;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic wait_word(input int target);
    int cyc = 0;
    while (n_accepted < target && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_word", n_accepted, target);
  endtask

  task automatic end_checks();
    repeat (3) @(negedge clk);
    chk("words", n_accepted, NUM_WORDS);
    chk("reads", n_issued, NUM_WORDS);
    chk("done_cnt", n_done, 1);
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("max_val", max_val, exp_max);
    chk("max_idx", max_idx, exp_max_idx);
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_crd", bus.crd, 0);
    chk("rst_csel", bus.csel, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", bus.caddr_rd, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_idx", bus.out_idx, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_max_idx", max_idx, 0);

    // Ramp data, consumer always ready: latency and throughput.
    fill_ramp();
    ready_duty = 100;
    begin_pass();
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("pre_busy", busy, 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("lat_busy", busy, 1);
    chk("lat_crd", bus.crd, 1);
    chk("lat_addr", bus.caddr_rd, 0);
    @(negedge clk);
    chk("lat_valid2", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_valid3", bus.out_valid, 1);
    chk("lat_idx", bus.out_idx, 0);
    wait_done(3000, cyc);
    chk("throughput", cyc, NUM_WORDS);
    end_checks();

    // Sparse consumer.
    ready_duty = 30;
    begin_pass();
    pulse_start();
    wait_done(20000, cyc);
    end_checks();

    // Tied maxima: first index wins.
    for (int i = 0; i < NUM_WORDS; i++) mem[i] = '0;
    mem[5]   = 13'h0FF0;
    mem[700] = 13'h0FF0;
    ready_duty = 60;
    begin_pass();
    pulse_start();
    wait_done(20000, cyc);
    end_checks();
    chk("tie_max_idx", max_idx, 5);

    // Long back-pressure right after start.
    fill_random(8191);
    ready_duty = 0;
    begin_pass();
    pulse_start();
    repeat (20) @(negedge clk);
    chk("bp_reads", n_issued, FIFO_DEPTH);
    chk("bp_crd", bus.crd, 0);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_idx", bus.out_idx, 0);
    ready_duty = 100;
    wait_done(3000, cyc);
    end_checks();

    // Start while busy is ignored; then a fresh pass resets the maximum.
    fill_ramp();
    ready_duty = 80;
    begin_pass();
    pulse_start();
    wait_word(300);
    pulse_start();
    wait_done(20000, cyc);
    end_checks();
    fill_random(4095);
    begin_pass();
    pulse_start();
    wait_done(20000, cyc);
    end_checks();

    // Asynchronous reset mid-pass.
    fill_ramp();
    ready_duty = 100;
    begin_pass();
    pulse_start();
    wait_word(512);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_crd", bus.crd, 0);
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_done", done, 0);
    chk("ar_max_val", max_val, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    fill_random(8191);
    ready_duty = 70;
    begin_pass();
    pulse_start();
    wait_done(20000, cyc);
    end_checks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
